// File: rtl/vx_ecc_scrubber.sv
// SECDED read-path stage: registers the decoded response, scrubs single-bit corrections, counts errors.
// Optional macro ECC_SCRUB_EN enables the scrub write-back FSM; otherwise the scrub port is tied off.
module vx_ecc_scrubber #(
  parameter int unsigned DATA_BITS  = 128,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic [DATA_BITS-1:0]  in_data,
  input  logic                  in_corrected,
  input  logic                  in_invalid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_BITS-1:0]  out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_error,
  output logic                  scrub_valid,
  input  logic                  scrub_ready,
  output logic [ADDR_WIDTH-1:0] scrub_addr,
  output logic [DATA_BITS-1:0]  scrub_data,
  input  logic                  cnt_clear,
  output logic [CNT_WIDTH-1:0]  cnt_corrected,
  output logic [CNT_WIDTH-1:0]  cnt_uncorrectable
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic accept;
  logic corr_only;

  assign accept    = in_valid & in_ready;
  // An invalid flag overrides a simultaneous corrected flag.
  assign corr_only = in_corrected & ~in_invalid;

  // One-entry response register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_error <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_tag   <= in_tag;
      out_error <= in_invalid;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating error counters; a same-cycle clear drops the increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_corrected     <= '0;
      cnt_uncorrectable <= '0;
    end else if (cnt_clear) begin
      cnt_corrected     <= '0;
      cnt_uncorrectable <= '0;
    end else if (accept) begin
      if (corr_only && (cnt_corrected != CNT_MAX))
        cnt_corrected <= cnt_corrected + CNT_WIDTH'(1);
      if (in_invalid && (cnt_uncorrectable != CNT_MAX))
        cnt_uncorrectable <= cnt_uncorrectable + CNT_WIDTH'(1);
    end
  end

`ifdef ECC_SCRUB_EN
  typedef enum logic {S_IDLE = 1'b0, S_SCRUB = 1'b1} state_t;
  state_t state;

  assign in_ready = (~out_valid | out_ready) & (state == S_IDLE);

  // Scrub FSM: hold the write-back request until the write port grants it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      scrub_valid <= 1'b0;
      scrub_addr  <= '0;
      scrub_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && corr_only) begin
            scrub_valid <= 1'b1;
            scrub_addr  <= in_addr;
            scrub_data  <= in_data;
            state       <= S_SCRUB;
          end
        end
        S_SCRUB: begin
          if (scrub_ready) begin
            scrub_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end
      endcase
    end
  end
`else
  logic                  unused_scrub_ready;
  logic [ADDR_WIDTH-1:0] unused_in_addr;

  assign unused_scrub_ready = scrub_ready;
  assign unused_in_addr     = in_addr;
  assign in_ready           = ~out_valid | out_ready;
  assign scrub_valid        = 1'b0;
  assign scrub_addr         = '0;
  assign scrub_data         = '0;
`endif

endmodule

// File: tb/tb_vx_ecc_scrubber.sv
// Directed self-checking bench for vx_ecc_scrubber (2-bit counters to reach saturation quickly).
module tb_vx_ecc_scrubber;

  localparam int unsigned DATA_BITS  = 128;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned TAG_WIDTH  = 8;
  localparam int unsigned CNT_WIDTH  = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic [DATA_BITS-1:0]  in_data;
  logic                  in_corrected;
  logic                  in_invalid;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_BITS-1:0]  out_data;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_error;
  logic                  scrub_valid;
  logic                  scrub_ready;
  logic [ADDR_WIDTH-1:0] scrub_addr;
  logic [DATA_BITS-1:0]  scrub_data;
  logic                  cnt_clear;
  logic [CNT_WIDTH-1:0]  cnt_corrected;
  logic [CNT_WIDTH-1:0]  cnt_uncorrectable;

  int total = 0;
  int bad   = 0;

  logic [DATA_BITS-1:0] data_a5;
  logic [DATA_BITS-1:0] data_c3;
  logic [DATA_BITS-1:0] data_b;

  vx_ecc_scrubber #(
    .DATA_BITS(DATA_BITS), .ADDR_WIDTH(ADDR_WIDTH),
    .TAG_WIDTH(TAG_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_tag(in_tag),
    .in_data(in_data), .in_corrected(in_corrected), .in_invalid(in_invalid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_error(out_error),
    .scrub_valid(scrub_valid), .scrub_ready(scrub_ready),
    .scrub_addr(scrub_addr), .scrub_data(scrub_data),
    .cnt_clear(cnt_clear), .cnt_corrected(cnt_corrected),
    .cnt_uncorrectable(cnt_uncorrectable)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [ADDR_WIDTH-1:0] a, input logic [TAG_WIDTH-1:0] t,
                       input logic [DATA_BITS-1:0] d, input logic c, input logic i);
    in_valid     = v;
    in_addr      = a;
    in_tag       = t;
    in_data      = d;
    in_corrected = c;
    in_invalid   = i;
  endtask

  // Bounded wait for in_ready; expiry is a failed comparison.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 10) begin
      tick();
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s: in_ready timeout got=%b want=1", name, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++;
    if ({out_valid, scrub_valid, out_error} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got=%b want=000", {out_valid, scrub_valid, out_error});
    end
    total++;
    if ({cnt_corrected, cnt_uncorrectable} !== '0) begin
      bad++;
      $display("FAIL reset_counters: got=%h/%h want=0/0", cnt_corrected, cnt_uncorrectable);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_clean();
    drive(1'b1, 32'h40, 8'd3, data_a5, 1'b0, 1'b0);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL clean_in_ready: got=%b want=1", in_ready);
    end
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    total++;
    if ({out_valid, out_tag, out_error, scrub_valid} !== {1'b1, 8'd3, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL clean_resp: got v=%b tag=%0d err=%b sv=%b want v=1 tag=3 err=0 sv=0",
               out_valid, out_tag, out_error, scrub_valid);
    end
    total++;
    if (out_data !== data_a5) begin
      bad++;
      $display("FAIL clean_data: got=%h want=%h", out_data, data_a5);
    end
    total++;
    if ({cnt_corrected, cnt_uncorrectable} !== '0) begin
      bad++;
      $display("FAIL clean_counters: got=%h/%h want=0/0", cnt_corrected, cnt_uncorrectable);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL clean_drain: out_valid got=%b want=0", out_valid);
    end
  endtask

  task automatic test_corrected();
    scrub_ready = 1'b0;
    drive(1'b1, 32'h80, 8'd5, data_c3, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    total++;
    if (cnt_corrected !== 2'd1) begin
      bad++;
      $display("FAIL corr_count: got=%0d want=1", cnt_corrected);
    end
    total++;
    if ({out_valid, out_error, out_tag} !== {1'b1, 1'b0, 8'd5}) begin
      bad++;
      $display("FAIL corr_resp: got v=%b err=%b tag=%0d want v=1 err=0 tag=5", out_valid, out_error, out_tag);
    end
`ifdef ECC_SCRUB_EN
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({scrub_valid, in_ready} !== 2'b10 || scrub_addr !== 32'h80 || scrub_data !== data_c3) begin
        bad++;
        $display("FAIL corr_scrub_hold[%0d]: got sv=%b rdy=%b addr=%h want sv=1 rdy=0 addr=80",
                 k, scrub_valid, in_ready, scrub_addr);
      end
      tick();
    end
    scrub_ready = 1'b1;
    tick();
    scrub_ready = 1'b0;
    total++;
    if ({scrub_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL corr_scrub_done: got sv=%b rdy=%b want sv=0 rdy=1", scrub_valid, in_ready);
    end
`else
    total++;
    if ({scrub_valid, in_ready, scrub_addr, scrub_data} !== {1'b0, 1'b1, 32'h0, 128'h0}) begin
      bad++;
      $display("FAIL corr_no_scrub: got sv=%b rdy=%b addr=%h want sv=0 rdy=1 addr=0",
               scrub_valid, in_ready, scrub_addr);
    end
    tick();
`endif
  endtask

  task automatic test_uncorrectable();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    total++;
    if ({cnt_corrected, cnt_uncorrectable} !== '0) begin
      bad++;
      $display("FAIL clear_counters: got=%h/%h want=0/0", cnt_corrected, cnt_uncorrectable);
    end
    drive(1'b1, 32'hC0, 8'd7, data_b, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    total++;
    if ({out_valid, out_error, out_tag, scrub_valid} !== {1'b1, 1'b1, 8'd7, 1'b0}) begin
      bad++;
      $display("FAIL unc_resp: got v=%b err=%b tag=%0d sv=%b want v=1 err=1 tag=7 sv=0",
               out_valid, out_error, out_tag, scrub_valid);
    end
    total++;
    if (out_data !== data_b) begin
      bad++;
      $display("FAIL unc_data: got=%h want=%h", out_data, data_b);
    end
    total++;
    if ({cnt_uncorrectable, cnt_corrected} !== {2'd1, 2'd0}) begin
      bad++;
      $display("FAIL unc_counts: got unc=%0d corr=%0d want unc=1 corr=0", cnt_uncorrectable, cnt_corrected);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL unc_no_stall: in_ready got=%b want=1", in_ready);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 32'h100, 8'd10, data_a5, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h110, 8'd11, data_c3, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({out_valid, in_ready, out_tag} !== {1'b1, 1'b0, 8'd10} || out_data !== data_a5) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%b rdy=%b tag=%0d want v=1 rdy=0 tag=10",
                 k, out_valid, in_ready, out_tag);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    for (int t = 11; t <= 13; t++) begin
      drive(1'b1, 32'(t) << 4, TAG_WIDTH'(t), data_c3, 1'b0, 1'b0);
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream_ready[%0d]: got=%b want=1", t, in_ready);
      end
      tick();
      total++;
      if ({out_valid, out_tag} !== {1'b1, TAG_WIDTH'(t)}) begin
        bad++;
        $display("FAIL stream_resp[%0d]: got v=%b tag=%0d want v=1 tag=%0d", t, out_valid, out_tag, t);
      end
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_drain: out_valid got=%b want=0", out_valid);
    end
  endtask

  task automatic test_saturation();
    logic [CNT_WIDTH-1:0] exp_cnt;
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    scrub_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_ready("sat_wait");
      drive(1'b1, 32'h200 + 32'(k), 8'(k), data_c3, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      exp_cnt = (k >= 2) ? 2'd3 : CNT_WIDTH'(k + 1);
      total++;
      if (cnt_corrected !== exp_cnt) begin
        bad++;
        $display("FAIL sat_corr[%0d]: got=%0d want=%0d", k, cnt_corrected, exp_cnt);
      end
    end
    for (int k = 0; k < 4; k++) begin
      wait_ready("sat_unc_wait");
      drive(1'b1, 32'h300, 8'd0, data_b, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    total++;
    if (cnt_uncorrectable !== 2'd3) begin
      bad++;
      $display("FAIL sat_unc: got=%0d want=3", cnt_uncorrectable);
    end
    wait_ready("clr_wait");
    cnt_clear = 1'b1;
    drive(1'b1, 32'h400, 8'd1, data_c3, 1'b1, 1'b0);
    tick();
    cnt_clear = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    total++;
    if ({cnt_corrected, cnt_uncorrectable} !== '0) begin
      bad++;
      $display("FAIL clear_wins: got=%0d/%0d want=0/0", cnt_corrected, cnt_uncorrectable);
    end
    tick();
    tick();
    scrub_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready   = 1'b0;
    scrub_ready = 1'b0;
    wait_ready("mid_wait");
    drive(1'b1, 32'h500, 8'd9, data_a5, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    total++;
`ifdef ECC_SCRUB_EN
    if ({out_valid, scrub_valid} !== 2'b11) begin
      bad++;
      $display("FAIL mid_pre: got v=%b sv=%b want v=1 sv=1", out_valid, scrub_valid);
    end
`else
    if ({out_valid, scrub_valid} !== 2'b10) begin
      bad++;
      $display("FAIL mid_pre: got v=%b sv=%b want v=1 sv=0", out_valid, scrub_valid);
    end
`endif
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({out_valid, scrub_valid, out_error} !== 3'b000 || cnt_corrected !== '0) begin
      bad++;
      $display("FAIL mid_reset: got v=%b sv=%b err=%b cnt=%0d want 0 0 0 0",
               out_valid, scrub_valid, out_error, cnt_corrected);
    end
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_recover: in_ready got=%b want=1", in_ready);
    end
  endtask

  initial begin
    data_a5 = {16{8'hA5}};
    data_c3 = {4{32'hC3C3_0F0F}};
    data_b  = {2{64'hDEAD_BEEF_0123_4567}};
    reset = 1'b0;
    out_ready = 1'b1;
    scrub_ready = 1'b0;
    cnt_clear = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    #2;
    test_reset();
    test_clean();
    test_corrected();
    test_uncorrectable();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
